// File: rtl/digit_scroll_ctrl_if.sv
// Digit input channel of the scroll sequencer: a BCD nibble offered under a
// valid/ready handshake. The producer drives the master side, the sequencer
// sits on the slave side.
interface digit_scroll_ctrl_if;
  logic [3:0] in_digit;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_digit,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_digit,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/digit_scroll_ctrl.sv
// Scroll sequencer for the 8-digit seven-segment scanner. Digits arrive over
// a valid/ready channel into a small FIFO; every scroll tick one buffered
// digit is shifted into the 8-nibble frame (slot 0 newest, slot 7 oldest).
// An empty FIFO at tick time raises a one-cycle underrun pulse instead.
module digit_scroll_ctrl #(
  parameter int         TICK_DIV   = 12500000,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input  logic                          clk,
  input  logic                          rst,
  digit_scroll_ctrl_if.slave            dig,
  input  logic                          pause,
  input  logic                          clear,
  output logic [31:0]                   frame,
  output logic                          frame_update,
  output logic                          underrun,
  output logic [15:0]                   shift_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST   = CW'(TICK_DIV - 1);
  localparam logic [LW-1:0] LEVEL_FULL  = LW'(FIFO_DEPTH);
  localparam logic [31:0]   BLANK_FRAME = {8{BLANK_CODE}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [31:0]     frame_q, frame_d;
  logic [15:0]     shift_cnt_q, shift_cnt_d;
  logic            upd_q, upd_d;
  logic            under_q, under_d;

  logic            full;
  logic            empty;
  logic            tick;
  logic            push;
  logic            pop;

  // Handshake and tick qualification; clear and rst both refuse new digits
  assign full         = (level_q == LEVEL_FULL);
  assign empty        = (level_q == '0);
  assign dig.in_ready = !full && !clear && !rst;
  assign push         = dig.in_valid && dig.in_ready;
  assign tick         = (cnt_q == TICK_LAST) && !pause;
  assign pop          = (state_q == SHIFT);

  assign frame        = frame_q;
  assign frame_update = upd_q;
  assign underrun     = under_q;
  assign shift_count  = shift_cnt_q;
  assign fifo_level   = level_q;

  // Next-state logic: tick counter, FIFO bookkeeping, scroll FSM; clear overrides all
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    frame_d     = frame_q;
    shift_cnt_d = shift_cnt_q;
    upd_d       = 1'b0;
    under_d     = 1'b0;

    // Counter holds its value while paused and resumes from it afterwards
    if (!pause) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    level_d = level_q + LW'(push) - LW'(pop);

    case (state_q)
      IDLE: begin
        if (tick && empty) begin
          under_d = 1'b1;
        end
        if (!empty) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (tick) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Shift runs to completion even if pause rises during it
        frame_d     = {frame_q[27:0], mem_q[rd_ptr_q]};
        shift_cnt_d = shift_cnt_q + 16'd1;
        upd_d       = 1'b1;
        state_d     = (level_d != '0) ? ARMED : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (clear) begin
      state_d     = IDLE;
      cnt_d       = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      frame_d     = BLANK_FRAME;
      shift_cnt_d = '0;
      upd_d       = 1'b0;
      under_d     = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter, FIFO pointers, frame and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      frame_q     <= BLANK_FRAME;
      shift_cnt_q <= '0;
      upd_q       <= 1'b0;
      under_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      frame_q     <= frame_d;
      shift_cnt_q <= shift_cnt_d;
      upd_q       <= upd_d;
      under_q     <= under_d;
    end
  end

  // Digit storage; contents need no reset because occupancy is tracked by level_q
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= dig.in_digit;
    end
  end

endmodule

// File: tb/tb_digit_scroll_ctrl.sv
// Scoreboard bench for digit_scroll_ctrl with TICK_DIV = 4, FIFO_DEPTH = 16.
// Each accepted digit pushes the frame/shift_count it must produce; a monitor
// pops and compares on every frame_update pulse.
module tb_digit_scroll_ctrl;
  localparam int TD = 4;
  localparam int FD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pause = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] frame;
  logic        frame_update;
  logic        underrun;
  logic [15:0] shift_count;
  logic [4:0]  fifo_level;

  digit_scroll_ctrl_if dig ();

  digit_scroll_ctrl #(
    .TICK_DIV   (TD),
    .FIFO_DEPTH (FD),
    .BLANK_CODE (4'hF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dig          (dig),
    .pause        (pause),
    .clear        (clear),
    .frame        (frame),
    .frame_update (frame_update),
    .underrun     (underrun),
    .shift_count  (shift_count),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int upd_cnt = 0;
  int un_cnt = 0;
  int un_last = 0;
  int un_prev = 0;
  int upd_cyc[$];
  logic [47:0] exp_q[$];
  logic [47:0] sb_e;
  logic [31:0] exp_frame = 32'hFFFFFFFF;
  logic [15:0] exp_cnt = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic model_push(input logic [3:0] d);
    exp_frame = {exp_frame[27:0], d};
    exp_cnt   = exp_cnt + 16'd1;
    exp_q.push_back({exp_cnt, exp_frame});
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_frame = 32'hFFFFFFFF;
    exp_cnt   = 16'd0;
  endtask

  // Offers one digit and returns on the negedge after it was accepted
  task automatic push_digit(input logic [3:0] d);
    int g;
    g = 0;
    dig.in_digit = d;
    dig.in_valid = 1'b1;
    #1;
    while (dig.in_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (dig.in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL push_timeout: digit %0d never accepted, ready=%b", d, dig.in_ready);
      dig.in_valid = 1'b0;
    end else begin
      model_push(d);
      @(negedge clk);
      dig.in_valid = 1'b0;
    end
  endtask

  // Returns on the first negedge (after the current one) showing frame_update
  task automatic wait_upd(input string name);
    int g;
    g = 0;
    @(negedge clk);
    while (frame_update !== 1'b1 && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (frame_update !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s: frame_update timeout, got 0 required 1", name);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (frame_update === 1'b1) begin
      upd_cnt++;
      upd_cyc.push_back(cyc);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: frame_update with frame 0x%08h cnt %0d, none required",
                 frame, shift_count);
      end else begin
        sb_e = exp_q.pop_front();
        if ({shift_count, frame} !== sb_e) begin
          bad++;
          $display("FAIL sb_frame: got cnt=%0d frame=0x%08h required cnt=%0d frame=0x%08h",
                   shift_count, frame, sb_e[47:32], sb_e[31:0]);
        end
      end
    end
    if (underrun === 1'b1) begin
      un_cnt++;
      un_prev = un_last;
      un_last = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] pi8 [8]  = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd2, 4'd6};
  logic [3:0] seq13[13] = '{4'd0, 4'd0, 4'd0, 4'd3, 4'd1, 4'd4, 4'd1, 4'd5,
                            4'd8, 4'd9, 4'd7, 4'd9, 4'd3};

  initial begin
    int g;
    int n;
    int rel;
    logic [31:0] f7;
    logic changed;

    dig.in_digit = 4'd0;
    dig.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state and idle underrun cadence
    chk("rst_frame", frame, 32'hFFFFFFFF);
    chk("rst_ready", dig.in_ready, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_shift_count", shift_count, 0);
    chk("rst_update", frame_update, 0);
    chk("rst_underrun", underrun, 0);
    @(negedge clk);
    // Ticks at release+3, +7, +11, +15; underrun one cycle later each
    repeat (17) @(negedge clk);
    chk("idle_underrun_count", un_cnt, 4);
    chk("idle_underrun_period", un_last - un_prev, TD);
    chk("idle_no_update", upd_cnt, 0);

    // Eight pi digits back-to-back
    upd_cyc.delete();
    for (int i = 0; i < 8; i++) push_digit(pi8[i]);
    g = 0;
    while (upd_cnt < 8 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("pi8_updates", upd_cnt, 8);
    for (int i = 1; i < upd_cyc.size() && i < 8; i++)
      chk("pi8_gap", upd_cyc[i] - upd_cyc[i-1], TD);
    chk("pi8_frame", frame, 32'h31415926);
    chk("pi8_count", shift_count, 8);

    // Fill under pause: 16 accepted, 17th held until the first pop
    pause = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 16; i++) push_digit(4'(i % 10));
    dig.in_digit = 4'd9;
    dig.in_valid = 1'b1;
    #1;
    chk("full_level", fifo_level, 16);
    chk("full_ready", dig.in_ready, 0);
    repeat (4) @(negedge clk);
    chk("full_hold_level", fifo_level, 16);
    pause = 1'b0;
    g = 0;
    while (dig.in_ready !== 1'b1 && g < 40) begin
      @(negedge clk);
      g++;
    end
    chk("drain_ready", dig.in_ready, 1);
    chk("drain_level", fifo_level, 15);
    if (dig.in_ready === 1'b1) model_push(4'd9);
    @(negedge clk);
    dig.in_valid = 1'b0;
    chk("refill_level", fifo_level, 16);
    pause = 1'b1;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    model_reset();
    @(negedge clk);
    clear = 1'b0;
    chk("flush_level", fifo_level, 0);
    chk("flush_frame", frame, 32'hFFFFFFFF);

    // Pause mid-count, then clear with five digits buffered
    for (int i = 0; i < 13; i++) push_digit(seq13[i]);
    chk("t4_level", fifo_level, 13);
    pause = 1'b0;
    n = 0;
    g = 0;
    while (n < 7 && g < 100) begin
      @(negedge clk);
      g++;
      if (frame_update === 1'b1) n++;
    end
    // Counter reads 1 here (tick two cycles ago), so it is held at 1
    pause = 1'b1;
    chk("t4_seven", n, 7);
    chk("t4_frame7", frame, 32'hF0003141);
    f7 = frame;
    changed = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (frame !== f7 || frame_update !== 1'b0) changed = 1'b1;
    end
    chk("pause_frozen", changed, 0);
    pause = 1'b0;
    rel = cyc;
    wait_upd("pause_resume_wait");
    pause = 1'b1;
    // SHIFT comes TD-1 cycles after release, the new frame one cycle later
    chk("pause_resume", cyc - rel, (TD - 1) + 1);
    chk("pre_clr_frame", frame, 32'h00031415);
    chk("pre_clr_level", fifo_level, 5);
    chk("pre_clr_count", shift_count, 8);
    @(negedge clk);
    clear = 1'b1;
    dig.in_digit = 4'd7;
    dig.in_valid = 1'b1;
    model_reset();
    #1;
    chk("clr_ready", dig.in_ready, 0);
    @(negedge clk);
    clear = 1'b0;
    dig.in_valid = 1'b0;
    chk("clr_frame", frame, 32'hFFFFFFFF);
    chk("clr_level", fifo_level, 0);
    chk("clr_count", shift_count, 0);
    chk("clr_update", frame_update, 0);

    // Push and pop in the same cycle at level 3 (counter 0 after clear)
    push_digit(4'd2);
    push_digit(4'd7);
    push_digit(4'd1);
    pause = 1'b0;
    repeat (4) @(negedge clk);
    push_digit(4'd8);
    chk("pp_level", fifo_level, 3);
    chk("pp_update", frame_update, 1);
    n = 1;
    g = 0;
    while (n < 4 && g < 60) begin
      @(negedge clk);
      g++;
      if (frame_update === 1'b1) n++;
    end
    pause = 1'b1;
    chk("pp_updates", n, 4);
    chk("pp_frame", frame, 32'hFFFF2718);
    chk("pp_level_end", fifo_level, 0);

    // Reset in the SHIFT cycle (counter held at 1: tick two cycles after release)
    push_digit(4'd4);
    pause = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_shift_ready", dig.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_shift_frame", frame, 32'hFFFFFFFF);
    chk("rst_shift_update", frame_update, 0);
    chk("rst_shift_level", fifo_level, 0);
    chk("rst_shift_count", shift_count, 0);
    repeat (6) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/digit_scroll_ctrl.md
Name: digit_scroll_ctrl

Overview:
- Sequencer feeding the 8-digit seven-segment scanner with a scrolling digit stream, for example successive pi digits from the generator.
- Accepts BCD digits over a valid/ready handshake and buffers them in a small FIFO.
- On every scroll tick, shifts one digit into an 8-nibble frame; the frame drives the scanner's per-digit inputs directly.
- Supports pause, clear and underrun signalling so the producer can run at any rate.

Parameters:
- TICK_DIV, 12500000: clock cycles per scroll tick, minimum 2 (4 shifts/s at 50 MHz).
- FIFO_DEPTH, 16: digit buffer entries; power of 2, minimum 2.
- BLANK_CODE, 4'hF: nibble loaded into empty frame slots; the scanner decodes it to the blank/dp pattern.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_digit  in  4  digit value 0..9; other codes are passed through unchanged
- in_valid  in  1  producer has a digit
- in_ready  out  1  block accepts a digit this cycle
- pause  in  1  level; freezes the tick counter and the frame
- clear  in  1  one-cycle pulse; flushes the FIFO and blanks the frame
- frame  out  32  slot k = frame[4k+3:4k]; slot 0 is the newest digit (rightmost), slot 7 the oldest
- frame_update  out  1  one-cycle pulse, coincident with a new frame value
- underrun  out  1  one-cycle pulse: a tick occurred with the FIFO empty
- shift_count  out  16  number of digits shifted into the frame since reset or clear; wraps modulo 2^16
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst high at a clock edge), all registered:
  - frame = {8{BLANK_CODE}}
  - FIFO empty, fifo_level = 0
  - tick counter = 0, shift_count = 0
  - frame_update = 0, underrun = 0
  - state = IDLE
- in_ready = !full && !clear && !rst (combinational). A push occurs when in_valid && in_ready. A push never occurs while the FIFO is full.
- Tick counter:
  - Counts 0..TICK_DIV-1 and holds while pause = 1.
  - tick is an internal pulse, high in the cycle where count == TICK_DIV-1 && !pause; the counter returns to 0 on the next edge.
- State machine:
  - IDLE: FIFO empty. On tick, assert underrun for one cycle (registered, visible the cycle after tick); frame is unchanged. Go to ARMED when fifo_level becomes nonzero.
  - ARMED: FIFO non-empty. On tick, go to SHIFT.
  - SHIFT: lasts one cycle.
    - frame <= {frame[27:0], head}; pop the FIFO.
    - frame_update = 1 in the following cycle, aligned with the new frame.
    - shift_count increments.
    - Next state is ARMED if fifo_level after the pop is > 0, otherwise IDLE.
- Latency:
  - The tick cycle is N; SHIFT is cycle N+1; the new frame and frame_update appear in cycle N+2.
  - A digit pushed into an empty FIFO is eligible for the first tick at least 2 cycles after the push.
- Simultaneous events:
  - A push and a pop in the same cycle leave fifo_level unchanged, and the data stays in order.
  - A push during SHIFT is accepted whenever in_ready = 1.
- pause:
  - Asserting pause during SHIFT does not abort the shift in progress.
  - No further ticks occur while pause = 1.
  - On release, counting resumes from the held value.
- clear (priority below rst, above everything else), effective on the next edge:
  - FIFO emptied, frame = all BLANK_CODE, tick counter = 0, shift_count = 0, state = IDLE.
  - No frame_update or underrun is generated for that cycle.
  - Any push presented during clear is dropped, because in_ready = 0.
- Reset or clear mid-SHIFT: the shift is discarded; the reset or clear values win.
- Wrap-around: FIFO pointers wrap modulo FIFO_DEPTH; shift_count wraps from 0xFFFF to 0x0000 silently.
- in_digit is passed through unchanged, so codes 10..15 reach the frame as-is.

Test Plan:
- Reset, TICK_DIV = 4 -> frame = 0xFFFFFFFF, in_ready = 1, fifo_level = 0; underrun pulses once every 4 cycles; frame_update stays 0.
- Push 3,1,4,1,5,9,2,6 back-to-back, then wait 8 ticks:
  - frame_update pulses 8 times, 4 cycles apart.
  - Final frame = 0x31415926, i.e. slot 7 = 3 and slot 0 = 6.
  - shift_count = 8.
- With FIFO_DEPTH = 16 and no ticks (pause = 1), push 17 digits -> in_ready drops after the 16th accept and the 17th is held; fifo_level = 16. Release pause: the first tick pops and in_ready returns to 1.
- pause high for 10 cycles mid-count -> no frame change during the pause; the next shift occurs exactly (TICK_DIV - held count) cycles after release.
- clear pulsed with 5 digits buffered and frame = 0x00031415 -> on the next cycle frame = 0xFFFFFFFF, fifo_level = 0, shift_count = 0; a push presented in the clear cycle is not accepted.
- rst asserted in the SHIFT cycle -> frame = 0xFFFFFFFF and no frame_update; a push in the same cycle as a pop, with fifo_level = 3, leaves fifo_level = 3 and the order is preserved.
